// File: rtl/multiplier_pkg.sv
// Shared constants for the multiply-accumulate block: parameter legality
// checks and saturation limits, all computed at elaboration time.
package multiplier_pkg;

   localparam int MAX_ACC_W = 128;

   function automatic bit widths_legal(input int wa, input int wb, input int wacc);
      return (wa >= 1) && (wb >= 1) && (wacc >= wa + wb) && (wacc <= MAX_ACC_W);
   endfunction

   function automatic bit pipe_legal(input int nb);
      return nb >= 1;
   endfunction

   // Limits are built in a wide vector and trimmed to the accumulator width by the caller.
   function automatic logic [MAX_ACC_W-1:0] sat_max_signed(input int w);
      logic [MAX_ACC_W-1:0] v;
      v = '0;
      for (int i = 0; i < w - 1; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_ACC_W-1:0] sat_min_signed(input int w);
      logic [MAX_ACC_W-1:0] v;
      v = '0;
      v[w-1] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_ACC_W-1:0] sat_max_unsigned(input int w);
      logic [MAX_ACC_W-1:0] v;
      v = '0;
      for (int i = 0; i < w; i++) v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mac_product_pipe.sv
// Signed/unsigned full-width multiplier followed by an NB_PIPE_REG-deep
// pipeline carrying the product together with its valid/signedness/clear flags.
module mac_product_pipe
   import multiplier_pkg::*;
#(
   parameter int WIDTH_A     = 16,
   parameter int WIDTH_B     = 16,
   parameter int NB_PIPE_REG = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_enable,
   input  logic                       i_valid,
   input  logic                       i_signed,
   input  logic                       i_clear,
   input  logic [WIDTH_A-1:0]         i_a,
   input  logic [WIDTH_B-1:0]         i_b,
   output logic                       o_valid,
   output logic                       o_signed,
   output logic                       o_clear,
   output logic [WIDTH_A+WIDTH_B-1:0] o_product
);

   localparam int PW = WIDTH_A + WIDTH_B;

   logic [PW-1:0]          w_aExt;
   logic [PW-1:0]          w_bExt;
   logic [PW-1:0]          w_product;
   logic [PW-1:0]          r_prod [NB_PIPE_REG];
   logic [NB_PIPE_REG-1:0] r_valid;
   logic [NB_PIPE_REG-1:0] r_signed;
   logic [NB_PIPE_REG-1:0] r_clear;

   // Extending both operands to the product width lets one modulo-2^PW
   // multiply serve both signed and unsigned beats.
   assign w_aExt    = {{WIDTH_B{i_signed & i_a[WIDTH_A-1]}}, i_a};
   assign w_bExt    = {{WIDTH_A{i_signed & i_b[WIDTH_B-1]}}, i_b};
   assign w_product = w_aExt * w_bExt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= '0;
         r_signed <= '0;
         r_clear  <= '0;
         for (int i = 0; i < NB_PIPE_REG; i++) r_prod[i] <= '0;
      end else if (i_enable) begin
         r_valid[0]  <= i_valid;
         r_signed[0] <= i_signed;
         r_clear[0]  <= i_clear;
         r_prod[0]   <= w_product;
         for (int i = 1; i < NB_PIPE_REG; i++) begin
            r_valid[i]  <= r_valid[i-1];
            r_signed[i] <= r_signed[i-1];
            r_clear[i]  <= r_clear[i-1];
            r_prod[i]   <= r_prod[i-1];
         end
      end
   end

   assign o_valid   = r_valid[NB_PIPE_REG-1];
   assign o_signed  = r_signed[NB_PIPE_REG-1];
   assign o_clear   = r_clear[NB_PIPE_REG-1];
   assign o_product = r_prod[NB_PIPE_REG-1];

endmodule

// File: rtl/multiplier_mac.sv
// Pipelined multiply-accumulate: products from mac_product_pipe are extended
// and added into a registered accumulator with sticky overflow and optional clamping.
module multiplier_mac
   import multiplier_pkg::*;
#(
   parameter int WIDTH_A     = 16,
   parameter int WIDTH_B     = 16,
   parameter int WIDTH_ACC   = 40,
   parameter int NB_PIPE_REG = 2,
   parameter int SATURATE    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 in_valid,
   input  logic                 is_signed,
   input  logic                 clear,
   input  logic [WIDTH_A-1:0]   a,
   input  logic [WIDTH_B-1:0]   b,
   output logic [WIDTH_ACC-1:0] acc,
   output logic                 out_valid,
   output logic                 overflow
);

   localparam int PW = WIDTH_A + WIDTH_B;
   localparam logic [WIDTH_ACC-1:0] L_SMAX = WIDTH_ACC'(sat_max_signed(WIDTH_ACC));
   localparam logic [WIDTH_ACC-1:0] L_SMIN = WIDTH_ACC'(sat_min_signed(WIDTH_ACC));
   localparam logic [WIDTH_ACC-1:0] L_UMAX = WIDTH_ACC'(sat_max_unsigned(WIDTH_ACC));

   generate
      if (!widths_legal(WIDTH_A, WIDTH_B, WIDTH_ACC)) begin : g_badWidth
         $error("multiplier_mac: WIDTH_ACC must cover WIDTH_A+WIDTH_B and fit MAX_ACC_W");
      end
      if (!pipe_legal(NB_PIPE_REG)) begin : g_badPipe
         $error("multiplier_mac: NB_PIPE_REG must be at least 1");
      end
   endgenerate

   logic                 w_pValid;
   logic                 w_pSigned;
   logic                 w_pClear;
   logic [PW-1:0]        w_product;
   logic [WIDTH_ACC-1:0] w_ext;
   logic [WIDTH_ACC:0]   w_sum;
   logic                 w_ovf;
   logic [WIDTH_ACC-1:0] w_clamp;
   logic [WIDTH_ACC-1:0] w_accNext;
   logic [WIDTH_ACC-1:0] r_acc;
   logic                 r_outValid;
   logic                 r_ovf;

   mac_product_pipe #(
      .WIDTH_A    (WIDTH_A),
      .WIDTH_B    (WIDTH_B),
      .NB_PIPE_REG(NB_PIPE_REG)
   ) u_productPipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (enable),
      .i_valid  (in_valid),
      .i_signed (is_signed),
      .i_clear  (clear),
      .i_a      (a),
      .i_b      (b),
      .o_valid  (w_pValid),
      .o_signed (w_pSigned),
      .o_clear  (w_pClear),
      .o_product(w_product)
   );

   assign w_ext = w_pSigned ? WIDTH_ACC'($signed(w_product)) : WIDTH_ACC'(w_product);
   assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

   // Overflow is judged in the arriving beat's own signedness.
   always_comb begin
      w_ovf   = 1'b0;
      w_clamp = L_UMAX;
      if (w_pSigned) begin
         w_ovf   = (r_acc[WIDTH_ACC-1] == w_ext[WIDTH_ACC-1]) &&
                   (w_sum[WIDTH_ACC-1] != r_acc[WIDTH_ACC-1]);
         w_clamp = r_acc[WIDTH_ACC-1] ? L_SMIN : L_SMAX;
      end else begin
         w_ovf   = w_sum[WIDTH_ACC];
      end
   end

   always_comb begin
      w_accNext = w_sum[WIDTH_ACC-1:0];
      if (w_pClear) begin
         w_accNext = w_ext;
      end else if (w_ovf && (SATURATE != 0)) begin
         w_accNext = w_clamp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_outValid <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (enable) begin
         r_outValid <= w_pValid;
         if (w_pValid) begin
            r_acc <= w_accNext;
            r_ovf <= w_pClear ? 1'b0 : (r_ovf | w_ovf);
         end
      end
   end

   assign acc       = r_acc;
   assign out_valid = r_outValid;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_multiplier_mac.sv
// Self-checking bench for multiplier_mac: directed scenarios against literal
// expectations plus randomized traffic against a tick-scheduled arithmetic model.
module tb_multiplier_mac;

   localparam int NB = 2;

   typedef struct {
      int          due;
      bit          sgn;
      bit          clr;
      logic [15:0] a;
      logic [15:0] b;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        in_valid;
   logic        is_signed;
   logic        clear;
   logic [15:0] a;
   logic [15:0] b;
   logic [39:0] acc40;
   logic [31:0] acc32s;
   logic [31:0] acc32w;
   logic        ov40, ov32s, ov32w;
   logic        vld40, vld32s, vld32w;

   int    nVectors = 0;
   int    nMiscompares = 0;
   int    mW[3] = '{40, 32, 32};
   bit    mSat[3] = '{1'b0, 1'b1, 1'b0};
   longint mAcc[3];
   bit    mOvf[3];
   bit    mOutValid;
   int    mTick;
   beat_t beatQ[$];

   multiplier_mac #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_ACC(40), .NB_PIPE_REG(NB), .SATURATE(0)) dut40 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .is_signed(is_signed),
      .clear(clear), .a(a), .b(b), .acc(acc40), .out_valid(vld40), .overflow(ov40));

   multiplier_mac #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_ACC(32), .NB_PIPE_REG(NB), .SATURATE(1)) dut32s (
      .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .is_signed(is_signed),
      .clear(clear), .a(a), .b(b), .acc(acc32s), .out_valid(vld32s), .overflow(ov32s));

   multiplier_mac #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_ACC(32), .NB_PIPE_REG(NB), .SATURATE(0)) dut32w (
      .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .is_signed(is_signed),
      .clear(clear), .a(a), .b(b), .acc(acc32w), .out_valid(vld32w), .overflow(ov32w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Arithmetic model of one accumulator: integer sums with range checks.
   function automatic void modelApply(input int k, input beat_t bt);
      longint prod, span, mx, mn, sacc, r;
      span = longint'(1) << mW[k];
      if (bt.sgn) prod = longint'($signed(bt.a)) * longint'($signed(bt.b));
      else        prod = longint'(bt.a) * longint'(bt.b);
      if (bt.clr) begin
         r = prod;
         mOvf[k] = 1'b0;
      end else if (bt.sgn) begin
         mx   = span / 2 - 1;
         mn   = -(span / 2);
         sacc = (mAcc[k] > mx) ? mAcc[k] - span : mAcc[k];
         r    = sacc + prod;
         if (r > mx || r < mn) begin
            mOvf[k] = 1'b1;
            if (mSat[k]) r = (r > mx) ? mx : mn;
         end
      end else begin
         r = mAcc[k] + prod;
         if (r > span - 1) begin
            mOvf[k] = 1'b1;
            if (mSat[k]) r = span - 1;
         end
      end
      mAcc[k] = ((r % span) + span) % span;
   endfunction

   function automatic void modelReset();
      beatQ.delete();
      mTick     = 0;
      mOutValid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mAcc[k] = 0;
         mOvf[k] = 1'b0;
      end
   endfunction

   // Drives one cycle of inputs, waits past the edge and advances the model.
   task automatic applyStimulus(input bit en, input bit v, input bit sg, input bit cl,
                                input logic [15:0] av, input logic [15:0] bv);
      beat_t bt;
      enable = en; in_valid = v; is_signed = sg; clear = cl; a = av; b = bv;
      @(posedge clk);
      #1;
      if (en) begin
         mTick++;
         mOutValid = 1'b0;
         if (beatQ.size() > 0 && beatQ[0].due == mTick) begin
            bt = beatQ.pop_front();
            mOutValid = 1'b1;
            for (int k = 0; k < 3; k++) modelApply(k, bt);
         end
         if (v) begin
            bt.due = mTick + NB; bt.sgn = sg; bt.clr = cl; bt.a = av; bt.b = bv;
            beatQ.push_back(bt);
         end
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; is_signed = 1'b0; clear = 1'b0; a = '0; b = '0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      nVectors++; if (acc40 !== 40'h0) begin nMiscompares++; $display("[TB] FAIL reset_acc: got %h expected %h", acc40, 40'h0); end
      nVectors++; if (vld40 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", vld40); end
      nVectors++; if (ov40 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", ov40); end
      nVectors++; if (acc32s !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_acc32: got %h expected %h", acc32s, 32'h0); end
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned_back_to_back();
      flush();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 16'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
      nVectors++; if (acc40 !== 40'h000000000F || vld40 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL uns_beat1: got %h/%b expected %h/1", acc40, vld40, 40'h000000000F); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      nVectors++; if (acc40 !== 40'h00FFFE0010 || vld40 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL uns_beat2: got %h/%b expected %h/1", acc40, vld40, 40'h00FFFE0010); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      nVectors++; if (acc40 !== 40'h01FFFC0011 || vld40 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL uns_beat3: got %h/%b expected %h/1", acc40, vld40, 40'h01FFFC0011); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      nVectors++; if (acc40 !== 40'h01FFFC0011 || vld40 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL uns_idle_hold: got %h/%b expected %h/0", acc40, vld40, 40'h01FFFC0011); end
   endtask

   task automatic test_signed();
      flush();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0003);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      nVectors++; if (acc40 !== 40'hFFFFFFFFFD) begin nMiscompares++; $display("[TB] FAIL signed_acc: got %h expected %h", acc40, 40'hFFFFFFFFFD); end
      nVectors++; if (ov40 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL signed_ovf: got %b expected 0", ov40); end
   endtask

   task automatic test_saturation();
      flush();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h8000, 16'h8000);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h8000);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
      nVectors++; if (acc32s !== 32'h40000000 || ov32s !== 1'b0) begin nMiscompares++; $display("[TB] FAIL sat_first: got %h/%b expected 40000000/0", acc32s, ov32s); end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h0001);
      nVectors++; if (acc32s !== 32'h7FFFFFFF || ov32s !== 1'b1) begin nMiscompares++; $display("[TB] FAIL sat_clamp: got %h/%b expected 7fffffff/1", acc32s, ov32s); end
      nVectors++; if (acc32w !== 32'h80000000 || ov32w !== 1'b1) begin nMiscompares++; $display("[TB] FAIL wrap_sum: got %h/%b expected 80000000/1", acc32w, ov32w); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      nVectors++; if (ov32s !== 1'b1 || ov32w !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovf_sticky: got %b/%b expected 1/1", ov32s, ov32w); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      nVectors++; if (acc32s !== 32'h1 || ov32s !== 1'b0 || ov32w !== 1'b0) begin nMiscompares++; $display("[TB] FAIL ovf_cleared: got %h/%b/%b expected 1/0/0", acc32s, ov32s, ov32w); end
   endtask

   task automatic test_stall();
      int pulses, pulseAt;
      flush();
      pulses = 0; pulseAt = -1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus((k < 1 || k > 4), (k == 0), 1'b0, (k == 0), 16'd7, 16'd9);
         if (vld40 === 1'b1) begin pulses++; pulseAt = k; end
      end
      nVectors++; if (pulses != 1 || pulseAt != 6) begin nMiscompares++; $display("[TB] FAIL stall_pulse: got %0d pulses at step %0d expected 1 at step 6", pulses, pulseAt); end
      nVectors++; if (acc40 !== 40'd63) begin nMiscompares++; $display("[TB] FAIL stall_acc: got %h expected %h", acc40, 40'd63); end
   endtask

   task automatic test_reset_in_flight();
      int strayValid;
      flush();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'd5, 16'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'd6, 16'd6);
      rst_n = 1'b0;
      #1;
      nVectors++; if (acc40 !== 40'h0 || vld40 !== 1'b0 || ov40 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL async_reset: got %h/%b/%b expected 0/0/0", acc40, vld40, ov40); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      strayValid = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         if (vld40 !== 1'b0) strayValid++;
      end
      nVectors++; if (strayValid != 0) begin nMiscompares++; $display("[TB] FAIL dropped_beats: got %0d stray pulses expected 0", strayValid); end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      nVectors++; if (acc40 !== 40'd4 || vld40 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL post_reset_acc: got %h/%b expected 4/1", acc40, vld40); end
   endtask

   task automatic test_random();
      logic [15:0] av, bv;
      bit en, v, sg, cl;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         en = ($urandom_range(0, 9) < 8);
         v  = ($urandom_range(0, 3) != 0);
         sg = $urandom_range(0, 1);
         cl = ($urandom_range(0, 15) == 0);
         av = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         bv = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         applyStimulus(en, v, sg, cl, av, bv);
         nVectors++; if (vld40 !== mOutValid) begin nMiscompares++; $display("[TB] FAIL rnd_valid cyc %0d: got %b expected %b", cyc, vld40, mOutValid); end
         nVectors++; if (acc40 !== mAcc[0][39:0]) begin nMiscompares++; $display("[TB] FAIL rnd_acc40 cyc %0d: got %h expected %h", cyc, acc40, mAcc[0][39:0]); end
         nVectors++; if (ov40 !== mOvf[0]) begin nMiscompares++; $display("[TB] FAIL rnd_ovf40 cyc %0d: got %b expected %b", cyc, ov40, mOvf[0]); end
         nVectors++; if (acc32s !== mAcc[1][31:0]) begin nMiscompares++; $display("[TB] FAIL rnd_acc32s cyc %0d: got %h expected %h", cyc, acc32s, mAcc[1][31:0]); end
         nVectors++; if (ov32s !== mOvf[1]) begin nMiscompares++; $display("[TB] FAIL rnd_ovf32s cyc %0d: got %b expected %b", cyc, ov32s, mOvf[1]); end
         nVectors++; if (acc32w !== mAcc[2][31:0]) begin nMiscompares++; $display("[TB] FAIL rnd_acc32w cyc %0d: got %h expected %h", cyc, acc32w, mAcc[2][31:0]); end
         nVectors++; if (ov32w !== mOvf[2]) begin nMiscompares++; $display("[TB] FAIL rnd_ovf32w cyc %0d: got %b expected %b", cyc, ov32w, mOvf[2]); end
      end
   endtask

   initial begin
      $display("[TB] multiplier_mac bench starting");
      test_reset();
      test_unsigned_back_to_back();
      test_signed();
      test_saturation();
      test_stall();
      test_reset_in_flight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
